// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
//   Shared constants and elaboration-time helpers for the pipelined adder tree.
//   - clog2()      : ceiling log2, used to bound the number of reduction levels
//   - sum_width()  : width of one partial sum after 'level' pairwise reductions
//   - num_nodes()  : number of partial sums held after 'level' reductions
//   - DEF_*        : default parameter values of pipelined_adder_tree
package adder_tree_pkg;

  localparam int DEF_ADDER_WIDTH    = 48;
  localparam int DEF_NUM_INPUTS     = 8;
  localparam int DEF_REDUCE_LEVELS  = 2;
  localparam int DEF_ACC_EXTRA_BITS = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Every pairwise add grows the result by one bit, so no sum can overflow.
  function automatic int sum_width(input int adder_width, input int level);
    return adder_width + level;
  endfunction

  function automatic int num_nodes(input int num_inputs, input int level);
    return num_inputs >> level;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level
//   One registered pairwise-reduction level of the adder tree.
//   Handshake: a level holds one entry (o_valid/o_data/o_last). It loads a new
//   entry whenever it is empty or the downstream level takes its entry in the
//   same cycle (o_ready = !o_valid || i_ready_dn). Upstream treats o_ready as
//   "my entry is consumed at this edge". A stalled level holds everything.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   i_valid      : upstream entry valid
//   i_data       : 2*NODES operands of IN_W bits, node n adds operands 2n, 2n+1
//   i_last       : group marker travelling alongside the data
//   o_ready      : this level loads at the next edge
//   o_valid      : registered entry valid
//   o_data       : NODES sums of IN_W+1 bits
//   o_last       : registered group marker
//   i_ready_dn   : downstream level loads at the next edge
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int IN_W  = 48,
  parameter int NODES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_valid,
  input  logic [2*NODES*IN_W-1:0]          i_data,
  input  logic                             i_last,
  output logic                             o_ready,
  output logic                             o_valid,
  output logic [NODES*sum_width(IN_W,1)-1:0] o_data,
  output logic                             o_last,
  input  logic                             i_ready_dn
);

  localparam int OUT_W = sum_width(IN_W, 1);

  logic                   r_valid;
  logic                   r_last;
  logic [NODES*OUT_W-1:0] r_data;
  logic [NODES*OUT_W-1:0] w_sums;
  logic                   w_load;

  assign w_load = !r_valid || i_ready_dn;

  always_comb begin
    w_sums = '0;
    for (int n = 0; n < NODES; n++) begin
      w_sums[n*OUT_W +: OUT_W] = OUT_W'(i_data[(2*n)*IN_W +: IN_W])
                               + OUT_W'(i_data[(2*n+1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      // Data only moves with a real entry, so bubbles leave the last sum in place.
      if (i_valid) begin
        r_data <= w_sums;
        r_last <= i_last;
      end
    end
  end

  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//   Registers NUM_INPUTS unsigned operands, reduces them pairwise through
//   REDUCE_LEVELS registered levels and emits NUM_INPUTS>>REDUCE_LEVELS sums.
//   Channel j is the sum of operands j*2^REDUCE_LEVELS .. (j+1)*2^REDUCE_LEVELS-1.
//   Handshake: a transfer happens on an edge where valid && ready. Every stage
//   loads when it is empty or its downstream loads, so in_ready is the only
//   combinational path (from out_ready down the valid chain) and a full
//   pipeline moves one vector per cycle.
//   Optional feature macro: ADDER_TREE_ACCUM_EN adds an accumulator stage that
//   folds tree results into per-channel running sums and emits on in_last.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready / in_data / in_last : operand vector input
//   out_valid / out_ready / out_data        : result output
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH      = DEF_ADDER_WIDTH,
  parameter int NUM_INPUTS       = DEF_NUM_INPUTS,
  parameter int REDUCE_LEVELS    = DEF_REDUCE_LEVELS,
  parameter int ACC_EXTRA_BITS   = DEF_ACC_EXTRA_BITS,
  localparam int NUM_OUT         = num_nodes(NUM_INPUTS, REDUCE_LEVELS),
  localparam int SUM_WIDTH       = sum_width(ADDER_WIDTH, REDUCE_LEVELS),
`ifdef ADDER_TREE_ACCUM_EN
  localparam int OUT_WIDTH       = SUM_WIDTH + ACC_EXTRA_BITS
`else
  localparam int OUT_WIDTH       = SUM_WIDTH
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_OUT*OUT_WIDTH-1:0]    out_data
);

  if (REDUCE_LEVELS > clog2(NUM_INPUTS)) begin : g_bad_levels
    $error("REDUCE_LEVELS exceeds log2(NUM_INPUTS)");
  end

  // Every level's sums fit in one shared bus width; the spare top bit keeps
  // the unused slice of each level non-empty for any parameter choice.
  localparam int BUS_W  = NUM_INPUTS * (ADDER_WIDTH + REDUCE_LEVELS) + 1;
  localparam int TREE_W = NUM_OUT * SUM_WIDTH;

  logic [BUS_W-1:0]         w_bus [0:REDUCE_LEVELS];
  logic [REDUCE_LEVELS:0]   w_valid;
  logic [REDUCE_LEVELS:0]   w_last;
  logic [REDUCE_LEVELS+1:0] w_rdy;
  logic [REDUCE_LEVELS:0]   w_pad_unused;
  logic [TREE_W-1:0]        w_tree;

  // Stage 0: operand register
  logic [NUM_INPUTS*ADDER_WIDTH-1:0] r_data0;
  logic                              r_valid0;
  logic                              r_last0;

  assign w_rdy[0] = !r_valid0 || w_rdy[1];
  assign in_ready = w_rdy[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid0 <= 1'b0;
      r_last0  <= 1'b0;
      r_data0  <= '0;
    end else if (w_rdy[0]) begin
      r_valid0 <= in_valid;
      if (in_valid) begin
        r_data0 <= in_data;
        r_last0 <= in_last;
      end
    end
  end

  assign w_bus[0]   = BUS_W'(r_data0);
  assign w_valid[0] = r_valid0;
  assign w_last[0]  = r_last0;

  for (genvar k = 1; k <= REDUCE_LEVELS; k++) begin : g_level
    localparam int LVL_IN_W  = sum_width(ADDER_WIDTH, k - 1);
    localparam int LVL_NODES = num_nodes(NUM_INPUTS, k);
    logic [LVL_NODES*(LVL_IN_W+1)-1:0] w_sums;

    adder_tree_level #(
      .IN_W  (LVL_IN_W),
      .NODES (LVL_NODES)
    ) u_level (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (w_valid[k-1]),
      .i_data     (w_bus[k-1][2*LVL_NODES*LVL_IN_W-1:0]),
      .i_last     (w_last[k-1]),
      .o_ready    (w_rdy[k]),
      .o_valid    (w_valid[k]),
      .o_data     (w_sums),
      .o_last     (w_last[k]),
      .i_ready_dn (w_rdy[k+1])
    );

    assign w_bus[k] = BUS_W'(w_sums);
  end

  for (genvar k = 0; k <= REDUCE_LEVELS; k++) begin : g_pad
    localparam int USED_W = num_nodes(NUM_INPUTS, k) * sum_width(ADDER_WIDTH, k);
    assign w_pad_unused[k] = ^w_bus[k][BUS_W-1:USED_W];
  end

  assign w_tree = w_bus[REDUCE_LEVELS][TREE_W-1:0];

`ifdef ADDER_TREE_ACCUM_EN
  logic [NUM_OUT*OUT_WIDTH-1:0] r_acc;
  logic [NUM_OUT*OUT_WIDTH-1:0] r_out;
  logic                         r_out_valid;
  logic [NUM_OUT*OUT_WIDTH-1:0] w_acc_sum;

  assign w_rdy[REDUCE_LEVELS+1] = !r_out_valid || out_ready;

  always_comb begin
    w_acc_sum = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      w_acc_sum[j*OUT_WIDTH +: OUT_WIDTH] = r_acc[j*OUT_WIDTH +: OUT_WIDTH]
                                          + OUT_WIDTH'(w_tree[j*SUM_WIDTH +: SUM_WIDTH]);
    end
  end

  // The closing beat moves acc+result into the output register and zeroes the
  // accumulators in the same edge. While that result waits for out_ready the
  // stage is stalled, so no later beat can touch the cleared accumulators
  // before the result is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_rdy[REDUCE_LEVELS+1]) begin
      r_out_valid <= w_valid[REDUCE_LEVELS] && w_last[REDUCE_LEVELS];
      if (w_valid[REDUCE_LEVELS]) begin
        if (w_last[REDUCE_LEVELS]) begin
          r_out <= w_acc_sum;
          r_acc <= '0;
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out;

  logic w_cfg_unused;
  assign w_cfg_unused = ^w_pad_unused;
`else
  assign w_rdy[REDUCE_LEVELS+1] = out_ready;
  assign out_valid = w_valid[REDUCE_LEVELS];
  assign out_data  = w_tree;

  // in_last still travels the pipeline but has no consumer in this build.
  logic w_cfg_unused;
  assign w_cfg_unused = ^{w_pad_unused, w_last[REDUCE_LEVELS], (ACC_EXTRA_BITS != 0)};
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
`timescale 1ns/1ps
module tb_pipelined_adder_tree;

  localparam int AW  = 48;
  localparam int NI  = 8;
  localparam int RL  = 2;
  localparam int AEB = 8;
  localparam int NO  = NI >> RL;
  localparam int SW  = AW + RL;
`ifdef ADDER_TREE_ACCUM_EN
  localparam int XLAT = 1;
`else
  localparam int XLAT = 0;
`endif
  localparam int OW    = SW + XLAT * AEB;
  localparam int LAT   = RL + 1 + XLAT;
  localparam int IN_W  = NI * AW;
  localparam int OUT_W = NO * OW;
  localparam int L3_OW = AW + 3 + XLAT * AEB;
  localparam int L0_OW = AW + XLAT * AEB;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b1;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;

  pipelined_adder_tree dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  // ---------------- REDUCE_LEVELS = 3 ----------------
  logic             l3_in_valid = 1'b0;
  logic             l3_in_ready;
  logic [IN_W-1:0]  l3_in_data = '0;
  logic             l3_out_valid;
  logic             l3_out_ready = 1'b1;
  logic [L3_OW-1:0] l3_out_data;

  pipelined_adder_tree #(.REDUCE_LEVELS(3)) dut_l3 (
    .clk(clk), .reset(reset), .in_valid(l3_in_valid), .in_ready(l3_in_ready),
    .in_data(l3_in_data), .in_last(1'b1), .out_valid(l3_out_valid),
    .out_ready(l3_out_ready), .out_data(l3_out_data)
  );

  // ---------------- REDUCE_LEVELS = 0 ----------------
  logic                l0_in_valid = 1'b0;
  logic                l0_in_ready;
  logic [IN_W-1:0]     l0_in_data = '0;
  logic                l0_out_valid;
  logic                l0_out_ready = 1'b1;
  logic [NI*L0_OW-1:0] l0_out_data;

  pipelined_adder_tree #(.REDUCE_LEVELS(0)) dut_l0 (
    .clk(clk), .reset(reset), .in_valid(l0_in_valid), .in_ready(l0_in_ready),
    .in_data(l0_in_data), .in_last(1'b1), .out_valid(l0_out_valid),
    .out_ready(l0_out_ready), .out_data(l0_out_data)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  // operand i = base + i + 1
  function automatic logic [IN_W-1:0] make_vec(input int base);
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < NI; i++) v[i*AW +: AW] = AW'(base + i + 1);
    return v;
  endfunction

  // ch0 = 1+2+3+4 + 4*base = 10+4*base, ch1 = 5+6+7+8 + 4*base = 26+4*base
  function automatic logic [OUT_W-1:0] exp_vec(input int base);
    logic [OUT_W-1:0] e;
    e = '0;
    e[0  +: OW] = OW'(10 + 4 * base);
    e[OW +: OW] = OW'(26 + 4 * base);
    return e;
  endfunction

  // Driver: apply inputs for one cycle, observe outputs mid-cycle, advance.
  task automatic drive_cycle(input logic iv, input logic [IN_W-1:0] d, input logic il,
                             input logic ordy, output logic irdy, output logic ov,
                             output logic [OUT_W-1:0] od);
    in_valid  = iv;
    in_data   = d;
    in_last   = il;
    out_ready = ordy;
    #1;
    irdy = in_ready;
    ov   = out_valid;
    od   = out_data;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic irdy, ov;
    logic [OUT_W-1:0] od;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b1, 1'b1, irdy, ov, od);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    #3; reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL release_state got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_ones;
    logic irdy, ov;
    logic [OUT_W-1:0] od, e;
    logic [OW-1:0] ch;
    int lat, outs;
    ch = 50'h3_FFFF_FFFF_FFFC;
    e  = {ch, ch};
    lat = 0; outs = 0;
    drive_cycle(1'b1, {NI{48'hFFFF_FFFF_FFFF}}, 1'b1, 1'b1, irdy, ov, od);
    checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL ones_in_ready got=%b want=1", irdy); end
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1, irdy, ov, od);
      if (ov) begin
        outs++;
        if (lat == 0) begin
          lat = k;
          checks++; if (od !== e) begin errors++; $display("FAIL ones_data got=%h want=%h", od, e); end
        end
      end
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL ones_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (outs != 1) begin errors++; $display("FAIL ones_count got=%0d want=1", outs); end
  endtask

  task automatic test_back_to_back;
    logic irdy, ov, iv;
    logic [OUT_W-1:0] od, e;
    logic [OUT_W-1:0] exp_q[$];
    int sent, got, first_c, last_c;
    sent = 0; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      iv = (sent < 10);
      drive_cycle(iv, make_vec(sent), 1'b1, 1'b1, irdy, ov, od);
      if (iv) begin
        checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b want=1", c, irdy); end
        if (irdy) begin exp_q.push_back(exp_vec(sent)); sent++; end
      end
      if (ov) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra got=%h want=none", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e) begin errors++; $display("FAIL stream_data n=%0d got=%h want=%h", got, od, e); end
        end
        got++;
      end
    end
    checks++; if (got != 10) begin errors++; $display("FAIL stream_count got=%0d want=10", got); end
    checks++; if (last_c - first_c != 9) begin errors++; $display("FAIL stream_consecutive span got=%0d want=9", last_c - first_c); end
  endtask

  task automatic test_backpressure;
    logic irdy, ov, ordy, prev_ov, prev_ordy, saw_stall;
    logic [OUT_W-1:0] od, e, prev_od;
    logic [OUT_W-1:0] exp_q[$];
    int sent, got;
    sent = 0; got = 0; prev_ov = 0; prev_ordy = 1; prev_od = '0; saw_stall = 0;
    for (int c = 0; c < 60 && got < 12; c++) begin
      ordy = !(c >= 4 && c <= 8);
      drive_cycle(sent < 12, make_vec(sent + 20), 1'b1, ordy, irdy, ov, od);
      if (!irdy) saw_stall = 1;
      if (sent < 12 && irdy) begin exp_q.push_back(exp_vec(sent + 20)); sent++; end
      if (prev_ov && !prev_ordy) begin
        checks++;
        if (ov !== 1'b1 || od !== prev_od) begin
          errors++; $display("FAIL bp_hold c=%0d got v=%b d=%h want v=1 d=%h", c, ov, od, prev_od);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got=%h want=none", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e) begin errors++; $display("FAIL bp_data n=%0d got=%h want=%h", got, od, e); end
        end
        got++;
      end
      prev_ov = ov; prev_ordy = ordy; prev_od = od;
    end
    checks++; if (!saw_stall) begin errors++; $display("FAIL bp_in_ready_fall got=never want=low while full"); end
    checks++; if (got != 12 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got=%0d left=%0d want 12/0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_inflight;
    logic irdy, ov;
    logic [OUT_W-1:0] od;
    int outs, lat;
    drive_cycle(1'b1, make_vec(40), 1'b1, 1'b0, irdy, ov, od);
    drive_cycle(1'b1, make_vec(41), 1'b1, 1'b0, irdy, ov, od);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0, irdy, ov, od);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_preload got out_valid=%b want=1", out_valid); end
    #2; reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_async_data got=%h want=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready got=%b want=1", in_ready); end
    #2; reset = 1'b0;
    @(posedge clk); #1;
    outs = 0; lat = 0;
    drive_cycle(1'b1, make_vec(50), 1'b1, 1'b1, irdy, ov, od);
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1, irdy, ov, od);
      if (ov) begin
        outs++;
        if (lat == 0) begin
          lat = k;
          checks++; if (od !== exp_vec(50)) begin errors++; $display("FAIL rst_first_out got=%h want=%h", od, exp_vec(50)); end
        end
      end
    end
    checks++; if (outs != 1 || lat != LAT) begin
      errors++; $display("FAIL rst_after got outs=%0d lat=%0d want 1/%0d", outs, lat, LAT);
    end
  endtask

  task automatic test_levels;
    logic [IN_W-1:0] ones, pat;
    logic [NI*L0_OW-1:0] e0;
    int lat, outs;
    ones = '0; pat = '0; e0 = '0;
    for (int i = 0; i < NI; i++) begin
      ones[i*AW +: AW] = AW'(1);
      pat[i*AW +: AW]  = 48'h1234_5678_9A00 + AW'(i * 32'h0101_0111);
      e0[i*L0_OW +: L0_OW] = L0_OW'(48'h1234_5678_9A00 + AW'(i * 32'h0101_0111));
    end
    // single-channel tree
    l3_in_data = ones; l3_in_valid = 1'b1; l3_out_ready = 1'b1;
    #1;
    checks++; if (l3_in_ready !== 1'b1) begin errors++; $display("FAIL l3_in_ready got=%b want=1", l3_in_ready); end
    @(posedge clk); #1;
    l3_in_valid = 1'b0;
    lat = 0; outs = 0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (l3_out_valid) begin
        outs++;
        if (lat == 0) begin
          lat = k;
          checks++; if (l3_out_data !== L3_OW'(8)) begin errors++; $display("FAIL l3_sum got=%0d want=8", l3_out_data); end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (lat != 4 + XLAT || outs != 1) begin
      errors++; $display("FAIL l3_timing got lat=%0d outs=%0d want %0d/1", lat, outs, 4 + XLAT);
    end
    // pass-through
    l0_in_data = pat; l0_in_valid = 1'b1; l0_out_ready = 1'b1;
    @(posedge clk); #1;
    l0_in_valid = 1'b0;
    lat = 0; outs = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (l0_out_valid) begin
        outs++;
        if (lat == 0) begin
          lat = k;
          checks++; if (l0_out_data !== e0) begin errors++; $display("FAIL l0_data got=%h want=%h", l0_out_data, e0); end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (lat != 1 + XLAT || outs != 1) begin
      errors++; $display("FAIL l0_timing got lat=%0d outs=%0d want %0d/1", lat, outs, 1 + XLAT);
    end
  endtask

`ifdef ADDER_TREE_ACCUM_EN
  task automatic test_accum;
    logic irdy, ov;
    logic [OUT_W-1:0] od, ones;
    logic [OW-1:0] c16, c4;
    int outs;
    ones = '0; outs = 0;
    for (int i = 0; i < NI; i++) ones[i*AW +: AW] = AW'(1);
    c16 = OW'(16); c4 = OW'(4);
    for (int b = 0; b < 4; b++) drive_cycle(1'b1, ones, (b == 3), 1'b1, irdy, ov, od);
    drive_cycle(1'b1, ones, 1'b1, 1'b1, irdy, ov, od);
    for (int k = 0; k < 12; k++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b1, irdy, ov, od);
      if (ov) begin
        checks++;
        if (outs == 0 && od !== {c16, c16}) begin errors++; $display("FAIL acc_group got=%h want=%h", od, {c16, c16}); end
        if (outs == 1 && od !== {c4, c4}) begin errors++; $display("FAIL acc_fresh got=%h want=%h", od, {c4, c4}); end
        outs++;
      end
    end
    checks++; if (outs != 2) begin errors++; $display("FAIL acc_count got=%0d want=2", outs); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    idle(2);
    test_back_to_back();
    idle(2);
    test_backpressure();
    idle(2);
    test_reset_inflight();
    idle(2);
    test_levels();
`ifdef ADDER_TREE_ACCUM_EN
    idle(2);
    test_accum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
